// File: rtl/dac_sat_slew.sv
// Output conditioner for the PMOD DA2 path: clips the signed PI output to a programmable
// window, rate-limits each DAC step, and flags/counts clip and slew events.
module dac_sat_slew #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 12,
  parameter int U_MAX    = 3723,
  parameter int U_MIN    = 0,
  parameter int SLEW_RST = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  data_in,
  input  logic             cfg_load,
  input  logic [OUT_W-1:0] cfg_max,
  input  logic [OUT_W-1:0] cfg_min,
  input  logic [OUT_W-1:0] cfg_slew,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [OUT_W-1:0] data_out,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic             slew_lim,
  output logic             cfg_err,
  output logic [CNT_W-1:0] sat_count
);

  localparam int PAD = IN_W + 1 - OUT_W;

  logic [OUT_W-1:0] max_q, min_q, slew_q;

  // Sample and a snapshot of the active config are captured together, so a
  // cfg_load on the same edge only reaches later samples.
  logic             r0_valid;
  logic [IN_W-1:0]  r0_data;
  logic [OUT_W-1:0] r0_max, r0_min, r0_slew;

  logic             s1_valid;
  logic [OUT_W-1:0] s1_clip, s1_slew;
  logic             s1_hi, s1_lo;

  logic signed [IN_W:0] x_ext, max_ext, min_ext;
  logic [OUT_W-1:0]     clip_val;
  logic                 clip_hi, clip_lo;

  always_comb begin
    x_ext    = $signed({r0_data[IN_W-1], r0_data});
    max_ext  = $signed({{PAD{1'b0}}, r0_max});
    min_ext  = $signed({{PAD{1'b0}}, r0_min});
    clip_hi  = 1'b0;
    clip_lo  = 1'b0;
    clip_val = r0_data[OUT_W-1:0];
    if (x_ext > max_ext) begin
      clip_hi  = 1'b1;
      clip_val = r0_max;
    end else if (x_ext < min_ext) begin
      clip_lo  = 1'b1;
      clip_val = r0_min;
    end
  end

  logic signed [OUT_W:0] diff, s_ext;
  logic [OUT_W-1:0]      slew_next;
  logic                  slew_hit;

  // The step is measured against the value currently on the DAC, so the
  // result always lies between the old output and the clipped target.
  always_comb begin
    diff      = $signed({1'b0, s1_clip}) - $signed({1'b0, data_out});
    s_ext     = $signed({1'b0, s1_slew});
    slew_next = s1_clip;
    slew_hit  = 1'b0;
    if (s1_slew != '0 && diff > s_ext) begin
      slew_next = data_out + s1_slew;
      slew_hit  = 1'b1;
    end else if (s1_slew != '0 && diff < -s_ext) begin
      slew_next = data_out - s1_slew;
      slew_hit  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      max_q     <= OUT_W'(U_MAX);
      min_q     <= OUT_W'(U_MIN);
      slew_q    <= OUT_W'(SLEW_RST);
      cfg_err   <= 1'b0;
      r0_valid  <= 1'b0;
      r0_data   <= '0;
      r0_max    <= '0;
      r0_min    <= '0;
      r0_slew   <= '0;
      s1_valid  <= 1'b0;
      s1_clip   <= '0;
      s1_slew   <= '0;
      s1_hi     <= 1'b0;
      s1_lo     <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= OUT_W'(U_MIN);
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
      slew_lim  <= 1'b0;
      sat_count <= '0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_load) begin
        if (cfg_min <= cfg_max) begin
          max_q  <= cfg_max;
          min_q  <= cfg_min;
          slew_q <= cfg_slew;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      r0_valid <= in_valid;
      r0_data  <= data_in;
      r0_max   <= max_q;
      r0_min   <= min_q;
      r0_slew  <= slew_q;

      s1_valid <= r0_valid;
      s1_clip  <= clip_val;
      s1_slew  <= r0_slew;
      s1_hi    <= clip_hi;
      s1_lo    <= clip_lo;

      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= slew_next;
        sat_hi   <= s1_hi;
        sat_lo   <= s1_lo;
        slew_lim <= slew_hit;
      end

      if (cnt_clr) begin
        sat_count <= '0;
      end else if (s1_valid && (s1_hi || s1_lo) && sat_count != '1) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_sat_slew.sv
// Self-checking bench for dac_sat_slew: integer reference model of clip/slew/count,
// output events compared with their expected arrival cycle.
module tb_dac_sat_slew;

  logic        clk = 1'b0;
  logic        reset_b, in_valid, cfg_load, cnt_clr;
  logic [15:0] data_in;
  logic [11:0] cfg_max, cfg_min, cfg_slew;
  logic        out_valid, sat_hi, sat_lo, slew_lim, cfg_err;
  logic [11:0] data_out;
  logic [7:0]  sat_count;

  dac_sat_slew #(.IN_W(16), .OUT_W(12), .U_MAX(3723), .U_MIN(0), .SLEW_RST(0), .CNT_W(8)) dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .data_in(data_in),
    .cfg_load(cfg_load), .cfg_max(cfg_max), .cfg_min(cfg_min), .cfg_slew(cfg_slew),
    .cnt_clr(cnt_clr), .out_valid(out_valid), .data_out(data_out), .sat_hi(sat_hi),
    .sat_lo(sat_lo), .slew_lim(slew_lim), .cfg_err(cfg_err), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [11:0] data;
    logic        hi;
    logic        lo;
    logic        sl;
    logic [7:0]  cnt;
  } ev_t;

  ev_t exp_q[$], obs_q[$];
  int  exp_err[$], obs_err[$];
  int  n_err = 0, n_chk = 0;

  int m_max = 3723, m_min = 0, m_slew = 0, m_out = 0, m_cnt = 0;

  always @(negedge clk) begin
    ev_t e;
    if (out_valid === 1'b1) begin
      e.cyc = cyc; e.data = data_out; e.hi = sat_hi; e.lo = sat_lo;
      e.sl = slew_lim; e.cnt = sat_count;
      obs_q.push_back(e);
    end
    if (cfg_err === 1'b1) obs_err.push_back(cyc);
  end

  function automatic string fmt(ev_t e);
    return $sformatf("cyc=%0d out=%0d hi=%0b lo=%0b sl=%0b cnt=%0d",
                     e.cyc, e.data, e.hi, e.lo, e.sl, e.cnt);
  endfunction

  // One clock of stimulus; the model predicts the result of any sample issued here
  // using the config in force before this edge.
  task automatic drive(input bit v, input int d, input bit ld = 0, input int mx = 0,
                       input int mn = 0, input int sl = 0, input bit clr = 0);
    ev_t e;
    int  c, clipped, step;
    e = '0;
    in_valid = v; data_in = 16'(d); cfg_load = ld;
    cfg_max = 12'(mx); cfg_min = 12'(mn); cfg_slew = 12'(sl); cnt_clr = clr;
    c = cyc;
    if (v) begin
      e.hi    = (d > m_max);
      e.lo    = !e.hi && (d < m_min);
      clipped = e.hi ? m_max : (e.lo ? m_min : d);
      step    = clipped - m_out;
      if (m_slew != 0 && step > m_slew) begin
        m_out = m_out + m_slew; e.sl = 1'b1;
      end else if (m_slew != 0 && step < -m_slew) begin
        m_out = m_out - m_slew; e.sl = 1'b1;
      end else begin
        m_out = clipped;
      end
      if ((e.hi || e.lo) && m_cnt < 255) m_cnt++;
      e.cyc = 32'(c + 3); e.data = 12'(m_out); e.cnt = 8'(m_cnt);
      exp_q.push_back(e);
    end
    if (ld) begin
      if (mn <= mx) begin
        m_max = mx; m_min = mn; m_slew = sl;
      end else begin
        exp_err.push_back(c + 1);
      end
    end
    if (clr) m_cnt = 0;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0);
  endtask

  task automatic apply_reset();
    obs_q.delete(); exp_q.delete(); obs_err.delete(); exp_err.delete();
    reset_b = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    data_in = '0; cfg_max = '0; cfg_min = '0; cfg_slew = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset_b = 1'b1;
    m_max = 3723; m_min = 0; m_slew = 0; m_out = 0; m_cnt = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (data_out !== 12'd0) begin
      n_err++; $display("FAIL reset_data_out: got %0d expected 0", data_out);
    end
    n_chk++;
    if ({out_valid, sat_hi, sat_lo, slew_lim, cfg_err, sat_count} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_flags: got ov=%0b hi=%0b lo=%0b sl=%0b err=%0b cnt=%0d expected all 0",
               out_valid, sat_hi, sat_lo, slew_lim, cfg_err, sat_count);
    end
  endtask

  task automatic test_pass_clip();
    drive(1, 1000);
    drive(1, 5000);
    drive(1, -200);
    idle(4);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL pass_clip_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL pass_clip_ev%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    obs_q.delete(); exp_q.delete();
    n_chk++;
    if ({data_out, sat_lo, sat_count} !== {12'd0, 1'b1, 8'd2}) begin
      n_err++;
      $display("FAIL pass_clip_final: got out=%0d lo=%0b cnt=%0d expected out=0 lo=1 cnt=2",
               data_out, sat_lo, sat_count);
    end
  endtask

  task automatic test_slew();
    drive(0, 0, 1, 3000, 100, 0);
    drive(1, 1000);
    drive(0, 0, 1, 3000, 100, 50);
    repeat (22) drive(1, 2000);
    idle(4);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL slew_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL slew_ev%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    obs_q.delete(); exp_q.delete();
    n_chk++;
    if ({data_out, slew_lim} !== {12'd2000, 1'b0}) begin
      n_err++; $display("FAIL slew_final: got out=%0d sl=%0b expected out=2000 sl=0", data_out, slew_lim);
    end
  endtask

  task automatic test_cfg_err();
    apply_reset();
    drive(0, 0, 1, 400, 500, 0);
    drive(1, 5000);
    idle(4);
    n_chk++;
    if (obs_err.size() != exp_err.size()) begin
      n_err++; $display("FAIL cfg_err_count: got %0d pulses expected %0d", obs_err.size(), exp_err.size());
    end
    for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++) begin
      n_chk++;
      if (obs_err[i] !== exp_err[i]) begin
        n_err++; $display("FAIL cfg_err_cyc%0d: got %0d expected %0d", i, obs_err[i], exp_err[i]);
      end
    end
    n_chk++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_err++;
      $display("FAIL cfg_err_sample: got %0d events, first %s expected %s", obs_q.size(),
               obs_q.size() > 0 ? fmt(obs_q[0]) : "none", fmt(exp_q[0]));
    end
    n_chk++;
    if (data_out !== 12'd3723) begin
      n_err++; $display("FAIL cfg_err_limit: got %0d expected 3723", data_out);
    end
    obs_q.delete(); exp_q.delete(); obs_err.delete(); exp_err.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) drive(1, ($urandom_range(0, 1) == 1) ? 5000 : -300);
    idle(4);
    n_chk++;
    if (sat_count !== 8'd255) begin
      n_err++; $display("FAIL b2b_saturate: got %0d expected 255", sat_count);
    end
    // clear lands on the same edge as a clipped sample's output
    drive(1, 5000);
    drive(0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    exp_q[exp_q.size() - 1].cnt = 8'd0;
    idle(4);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL b2b_ev%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    obs_q.delete(); exp_q.delete();
    n_chk++;
    if (sat_count !== 8'd0) begin
      n_err++; $display("FAIL b2b_clear: got %0d expected 0", sat_count);
    end
  endtask

  task automatic test_reset_inflight();
    drive(1, 2000);
    apply_reset();
    idle(4);
    n_chk++;
    if (obs_q.size() != 0 || data_out !== 12'd0) begin
      n_err++; $display("FAIL inflight_drop: got %0d events out=%0d expected 0 events out=0", obs_q.size(), data_out);
    end
    obs_q.delete();
    drive(1, 3500, 1, 3000, 0, 0);
    drive(1, 3500);
    idle(4);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL same_edge_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL same_edge_ev%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit v, ld;
      int d, mx, mn, sl;
      v  = ($urandom_range(0, 2) != 0);
      d  = int'($urandom_range(0, 7000)) - 1000;
      ld = ($urandom_range(0, 11) == 0);
      mn = $urandom_range(0, 2200);
      mx = $urandom_range(1500, 4095);
      sl = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 300);
      drive(v, d, ld, mx, mn, sl);
    end
    idle(4);
    n_chk++;
    if (obs_q.size() != exp_q.size() || obs_err.size() != exp_err.size()) begin
      n_err++;
      $display("FAIL random_count: got %0d events %0d errs expected %0d events %0d errs",
               obs_q.size(), obs_err.size(), exp_q.size(), exp_err.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL random_ev%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
    for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++) begin
      n_chk++;
      if (obs_err[i] !== exp_err[i]) begin
        n_err++; $display("FAIL random_err%0d: got cyc %0d expected %0d", i, obs_err[i], exp_err[i]);
      end
    end
    obs_q.delete(); exp_q.delete(); obs_err.delete(); exp_err.delete();
  endtask

  initial begin
    test_reset();
    test_pass_clip();
    test_slew();
    test_cfg_err();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
